// File: rtl/mult_div_unit_pkg.sv
// Shared MDU constants: md_op encodings, default latencies and FSM state type.
// The controller decode imports the same package so both sides agree on encodings.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W           = 16;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Pipeline-to-MDU bundle: issue side (start/op/operands/read select) and status/result.
interface mdu_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rd_sel;
  logic        busy;
  logic        stall_req;
  logic [31:0] rd_data;

  modport master (
    output start, md_op, rs_val, rt_val, rd_sel,
    input  busy, stall_req, rd_data
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, rd_sel,
    output busy, stall_req, rd_data
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. Results are computed at
// issue, held in pending registers, and committed when the latency counter expires.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);

  mdu_state_e         r_state;
  logic [CNT_W-1:0]   r_count;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic               r_busy;
  logic [31:0]        r_pend_hi;
  logic [31:0]        r_pend_lo;
  logic               r_pend_we;

  logic signed [63:0] w_ext_a;
  logic signed [63:0] w_ext_b;
  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic [31:0]        w_abs_a;
  logic [31:0]        w_abs_b;
  logic [31:0]        w_uq_abs;
  logic [31:0]        w_ur_abs;
  logic [31:0]        w_squo;
  logic [31:0]        w_srem;
  logic [31:0]        w_uquo;
  logic [31:0]        w_urem;
  logic               w_div_zero;

  // Operand-level arithmetic evaluated combinationally at issue time.
  always_comb begin
    w_ext_a    = $signed({{32{bus.rs_val[31]}}, bus.rs_val});
    w_ext_b    = $signed({{32{bus.rt_val[31]}}, bus.rt_val});
    w_prod_s   = w_ext_a * w_ext_b;
    w_prod_u   = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};
    w_div_zero = (bus.rt_val == 32'd0);
    w_abs_a    = bus.rs_val[31] ? (32'd0 - bus.rs_val) : bus.rs_val;
    w_abs_b    = bus.rt_val[31] ? (32'd0 - bus.rt_val) : bus.rt_val;
    w_uq_abs   = 32'd0;
    w_ur_abs   = 32'd0;
    w_uquo     = 32'd0;
    w_urem     = 32'd0;
    if (w_div_zero) begin
      w_uq_abs = 32'd0;
      w_ur_abs = 32'd0;
    end else begin
      // Magnitude division keeps 0x80000000 / -1 well defined: quotient wraps to 0x80000000.
      w_uq_abs = w_abs_a / w_abs_b;
      w_ur_abs = w_abs_a % w_abs_b;
      w_uquo   = bus.rs_val / bus.rt_val;
      w_urem   = bus.rs_val % bus.rt_val;
    end
    w_squo = (bus.rs_val[31] ^ bus.rt_val[31]) ? (32'd0 - w_uq_abs) : w_uq_abs;
    w_srem = bus.rs_val[31] ? (32'd0 - w_ur_abs) : w_ur_abs;
  end

  // FSM, latency counter, pending results and HI/LO architectural state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_count   <= {CNT_W{1'b0}};
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_busy    <= 1'b0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_we <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            case (bus.md_op)
              MD_MULT: begin
                r_pend_hi <= w_prod_s[63:32];
                r_pend_lo <= w_prod_s[31:0];
                r_pend_we <= 1'b1;
                r_count   <= CNT_W'(MULT_CYCLES);
                r_state   <= ST_BUSY;
                r_busy    <= 1'b1;
              end
              MD_MULTU: begin
                r_pend_hi <= w_prod_u[63:32];
                r_pend_lo <= w_prod_u[31:0];
                r_pend_we <= 1'b1;
                r_count   <= CNT_W'(MULT_CYCLES);
                r_state   <= ST_BUSY;
                r_busy    <= 1'b1;
              end
              MD_DIV: begin
                r_pend_hi <= w_srem;
                r_pend_lo <= w_squo;
                r_pend_we <= ~w_div_zero;
                r_count   <= CNT_W'(DIV_CYCLES);
                r_state   <= ST_BUSY;
                r_busy    <= 1'b1;
              end
              MD_DIVU: begin
                r_pend_hi <= w_urem;
                r_pend_lo <= w_uquo;
                r_pend_we <= ~w_div_zero;
                r_count   <= CNT_W'(DIV_CYCLES);
                r_state   <= ST_BUSY;
                r_busy    <= 1'b1;
              end
              MD_MTHI: r_hi <= bus.rs_val;
              MD_MTLO: r_lo <= bus.rs_val;
              default: ;
            endcase
          end
        end
        ST_BUSY: begin
          if (r_count <= CNT_W'(1)) begin
            if (r_pend_we) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_count <= {CNT_W{1'b0}};
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_count <= r_count - CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.stall_req = r_busy | (bus.start & is_arith(bus.md_op));
  assign bus.rd_data   = bus.rd_sel ? r_hi : r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed HI/LO and latency expectations.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  mdu_if bus();

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reads HI then LO through the combinational read port.
  task automatic read_hl(output logic [31:0] hi, output logic [31:0] lo);
    bus.rd_sel = 1'b1;
    #1 hi = bus.rd_data;
    bus.rd_sel = 1'b0;
    #1 lo = bus.rd_data;
  endtask

  task automatic check_hl(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] hi, lo;
    read_hl(hi, lo);
    check_eq({tag, " HI"}, hi, exp_hi);
    check_eq({tag, " LO"}, lo, exp_lo);
  endtask

  // Called at a negedge; pulses start for one cycle, checking stall_req before the edge.
  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic exp_stall);
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = a;
    bus.rt_val = b;
    #1 check_eq({tag, " stall@start"}, {31'd0, bus.stall_req}, {31'd0, exp_stall});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts remaining busy cycles (bounded), checking stall_req in each one.
  task automatic wait_idle(input string tag, input int exp_cycles);
    int n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      if (bus.stall_req !== 1'b1) check_eq({tag, " stall@busy"}, {31'd0, bus.stall_req}, 32'd1);
      n++;
      @(negedge clk);
    end
    check_eq({tag, " busy cycles"}, n, exp_cycles);
  endtask

  initial begin
    logic [31:0] hi, lo;
    int n;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.md_op  = 3'd0;
    bus.rs_val = 32'd0;
    bus.rt_val = 32'd0;
    bus.rd_sel = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset busy", {31'd0, bus.busy}, 32'd0);
    check_eq("reset stall", {31'd0, bus.stall_req}, 32'd0);
    check_hl("reset", 32'd0, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
    wait_idle("mult", 5);
    check_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    issue("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b1);
    wait_idle("multu", 5);
    check_hl("multu", 32'h0000_0002, 32'hFFFF_FFFA);

    issue("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_idle("div", 10);
    check_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue("divu", MD_DIVU, 32'd7, 32'd2, 1'b1);
    wait_idle("divu", 10);
    check_hl("divu", 32'd1, 32'd3);

    // MTHI: no stall, no bypass onto rd_data before the edge, one-cycle write.
    bus.start  = 1'b1;
    bus.md_op  = MD_MTHI;
    bus.rs_val = 32'h1234_5678;
    bus.rd_sel = 1'b1;
    #1 check_eq("mthi stall@start", {31'd0, bus.stall_req}, 32'd0);
    check_eq("mthi no bypass", bus.rd_data, 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("mthi busy", {31'd0, bus.busy}, 32'd0);
    check_hl("mthi", 32'h1234_5678, 32'd3);

    issue("divu0", MD_DIVU, 32'd99, 32'd0, 1'b1);
    wait_idle("divu0", 10);
    check_hl("divu0", 32'h1234_5678, 32'd3);

    issue("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle("divovf", 10);
    check_hl("divovf", 32'd0, 32'h8000_0000);

    issue("mtlo", MD_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0);
    check_eq("mtlo busy", {31'd0, bus.busy}, 32'd0);
    check_hl("mtlo", 32'd0, 32'hCAFE_F00D);

    issue("undef", 3'd6, 32'h1111_1111, 32'h2222_2222, 1'b0);
    check_eq("undef busy", {31'd0, bus.busy}, 32'd0);
    check_hl("undef", 32'd0, 32'hCAFE_F00D);

    // Reset in the third busy cycle aborts the multiply without a commit.
    issue("mthi2", MD_MTHI, 32'h0BAD_BEEF, 32'd0, 1'b0);
    issue("abort", MD_MULT, 32'h10, 32'h10, 1'b1);
    repeat (2) @(negedge clk);
    check_eq("abort busy before", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort busy", {31'd0, bus.busy}, 32'd0);
    check_hl("abort", 32'd0, 32'd0);
    repeat (10) @(negedge clk);
    check_eq("abort late busy", {31'd0, bus.busy}, 32'd0);
    check_hl("abort late", 32'd0, 32'd0);

    // Second start while busy is ignored; only 5*7 commits.
    issue("first", MD_MULTU, 32'd5, 32'd7, 1'b1);
    issue("second", MD_DIVU, 32'd100, 32'd3, 1'b1);
    wait_idle("first", 4);
    check_hl("first", 32'd0, 32'd35);
    repeat (12) @(negedge clk);
    check_eq("second ignored busy", {31'd0, bus.busy}, 32'd0);
    check_hl("second ignored", 32'd0, 32'd35);

    // rd_data keeps the pre-op values for the whole busy window.
    issue("rdsel", MD_MULTU, 32'h0001_0000, 32'h0001_0003, 1'b1);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      read_hl(hi, lo);
      if (hi !== 32'd0 || lo !== 32'd35) begin
        check_eq("rdsel old HI", hi, 32'd0);
        check_eq("rdsel old LO", lo, 32'd35);
      end
      n++;
      @(negedge clk);
    end
    check_eq("rdsel busy cycles", n, 5);
    check_hl("rdsel new", 32'd1, 32'h0003_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  high for one cycle to issue the op on md_op; valid only from the E stage.
REQ-006 md_op  input  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 rs_val  input  32  operand A, already forwarded.
REQ-008 rt_val  input  32  operand B, already forwarded.
REQ-009 rd_sel  input  1  read select: 0 selects LO, 1 selects HI.
REQ-010 busy  output  1  high while an arithmetic op is in flight.
REQ-011 stall_req  output  1  busy OR (start AND op is arithmetic); drives the D-stage stall for any MDU-class instruction.
REQ-012 rd_data  output  32  HI or LO as chosen by rd_sel (mfhi/mflo path).

Function
REQ-013 The block SHALL keep internal 32-bit registers HI and LO, a 2-state FSM (IDLE, BUSY), a down-counter, and pending-result registers.
REQ-014 In IDLE, start with MULT/MULTU/DIV/DIVU SHALL capture operands, load the counter with MULT_CYCLES or DIV_CYCLES, and move to BUSY; busy SHALL go high on the next edge.
REQ-015 MULT: {HI,LO} = signed(rs)*signed(rt), 64-bit. MULTU: unsigned 64-bit product.
REQ-016 DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend. DIVU: unsigned quotient and remainder.
REQ-017 Divide by zero (rt_val==0) SHALL still occupy DIV_CYCLES; HI and LO SHALL then remain unchanged.
REQ-018 Signed overflow case 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-019 In BUSY the counter SHALL decrement each cycle; on the edge where it reaches 0, HI/LO SHALL commit, the FSM SHALL return to IDLE, and busy SHALL drop.
REQ-020 HI/LO SHALL not be visible on rd_data until commit; rd_data during BUSY SHALL show the old values.
REQ-021 MTHI/MTLO in IDLE SHALL write rs_val to HI/LO at the next edge, SHALL not assert busy, and SHALL take 1 cycle.
REQ-022 start during BUSY SHALL be ignored; the pipeline guarantees it does not happen via stall_req.
REQ-023 rd_data SHALL be purely combinational from HI/LO and rd_sel, with no same-cycle bypass of an MTHI/MTLO write.
REQ-024 Undefined md_op values with start=1 SHALL be a no-op.

Reset
REQ-025 reset SHALL force IDLE, counter=0, HI=0, LO=0, busy=0, stall_req=0, and rd_data=0 at the next edge.
REQ-026 reset during BUSY SHALL abort the op with no commit; reset has priority over start.

Structure
REQ-027 md_op encodings and the MULT_CYCLES/DIV_CYCLES defaults SHALL live in the shared constants file, which the controller decode also uses.
REQ-028 The block SHALL be a single module with no sub-module; product and quotient SHALL use behavioural operators computed at capture and held in the pending registers.

Verification
REQ-029 MULT rs=0xFFFFFFFE (-2), rt=3 -> busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x2, LO=0xFFFFFFFA.
REQ-030 DIV rs=0xFFFFFFF9 (-7), rt=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-031 MTHI 0x12345678 then DIVU by 0 -> busy for 10 cycles, HI stays 0x12345678, LO unchanged.
REQ-032 MULT started, reset asserted in the 3rd busy cycle -> next cycle busy=0, HI=LO=0; no later commit.
REQ-033 Second start issued while busy -> ignored; only the first result commits, and stall_req stays high throughout.
REQ-034 rd_sel toggled during BUSY -> rd_data shows pre-op HI/LO until the commit edge, then the new values.
